// File: rtl/nebula_wb_pkg.sv
// Shared types and constants for the Wishbone slave sequencer.
package nebula_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } seq_state_e;

    localparam int          IDX_FIELD_MSB    = 23;
    localparam int          IDX_FIELD_LSB    = 16;
    localparam int          IDX_W            = IDX_FIELD_MSB - IDX_FIELD_LSB + 1;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBADD_C0DE;
    localparam logic [31:0] ADR_TRUNC_MASK   = 32'h0000_FFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_seq_timer.sv
// Cycle counter for the WAIT state; expired_o flags the last allowed wait cycle.
module wb_seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_o
);

    localparam int           W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/wb_slave_sequencer.sv
// Registered Wishbone sequencer: decodes the slave index, strobes one slave,
// waits for its ack (bounded by a timeout) and returns data or an error ack.
module wb_slave_sequencer
    import nebula_wb_pkg::*;
#(
    parameter int          NUM_TEAMS = 1,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA,
    localparam int         NUM_SLV   = NUM_TEAMS + 3
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_SLV-1:0]      slv_stb_o,
    output logic                    slv_cyc_o,
    output logic                    slv_we_o,
    output logic [3:0]              slv_sel_o,
    output logic [31:0]             slv_dat_o,
    output logic [31:0]             slv_adr_o,
    input  logic [NUM_SLV-1:0]      slv_ack_i,
    input  logic [32*NUM_SLV-1:0]   slv_dat_i,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [15:0]             err_count_o
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_SLV - 1);

    seq_state_e         state_q, state_d;
    logic [NUM_SLV-1:0] slv_stb_q, slv_stb_d;
    logic               slv_cyc_q, slv_cyc_d;
    logic               slv_we_q, slv_we_d;
    logic [3:0]         slv_sel_q, slv_sel_d;
    logic [31:0]        slv_dat_q, slv_dat_d;
    logic [31:0]        slv_adr_q, slv_adr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wbs_ack_q, wbs_ack_d;
    logic [31:0]        wbs_dat_q, wbs_dat_d;
    logic               err_q, err_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]   req_idx;
    logic               req_valid;
    logic               sel_ack;
    logic [31:0]        sel_dat;
    logic               tmr_expired;
    logic               unused_adr_bits;

    // Index 0 is reserved; anything past the GPIO slot is unmapped.
    assign req_idx         = wbs_adr_i[IDX_FIELD_MSB:IDX_FIELD_LSB];
    assign req_valid       = (req_idx != '0) && (req_idx <= MAX_IDX);
    assign unused_adr_bits = ^wbs_adr_i[31:IDX_FIELD_MSB+1];

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ack = slv_ack_i[k];
                sel_dat = slv_dat_i[32*k +: 32];
            end
        end
    end

    wb_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .clr       (state_q == ST_IDLE),
        .en        (state_q == ST_WAIT),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        slv_stb_d = slv_stb_q;
        slv_cyc_d = slv_cyc_q;
        slv_we_d  = slv_we_q;
        slv_sel_d = slv_sel_q;
        slv_dat_d = slv_dat_q;
        slv_adr_d = slv_adr_q;
        idx_d     = idx_q;
        wbs_ack_d = 1'b0;
        wbs_dat_d = '0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    slv_we_d  = wbs_we_i;
                    slv_sel_d = wbs_sel_i;
                    slv_dat_d = wbs_dat_i;
                    slv_adr_d = wbs_adr_i & ADR_TRUNC_MASK;
                    idx_d     = req_idx;
                    if (req_valid) begin
                        state_d   = ST_WAIT;
                        slv_cyc_d = 1'b1;
                        slv_stb_d = NUM_SLV'(1) << req_idx;
                    end else begin
                        state_d   = ST_ERR;
                        wbs_ack_d = 1'b1;
                        wbs_dat_d = ERR_DATA;
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc16(err_cnt_q);
                    end
                end
            end
            ST_WAIT: begin
                // Master abort wins over a same-cycle slave ack or timeout.
                if (!wbs_cyc_i) begin
                    state_d   = ST_IDLE;
                    slv_stb_d = '0;
                    slv_cyc_d = 1'b0;
                end else if (sel_ack) begin
                    state_d   = ST_RESP;
                    slv_stb_d = '0;
                    slv_cyc_d = 1'b0;
                    wbs_ack_d = 1'b1;
                    wbs_dat_d = sel_dat;
                end else if (tmr_expired) begin
                    state_d   = ST_ERR;
                    slv_stb_d = '0;
                    slv_cyc_d = 1'b0;
                    wbs_ack_d = 1'b1;
                    wbs_dat_d = ERR_DATA;
                    err_d     = 1'b1;
                    err_cnt_d = sat_inc16(err_cnt_q);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            slv_stb_q <= '0;
            slv_cyc_q <= 1'b0;
            slv_we_q  <= 1'b0;
            slv_sel_q <= '0;
            slv_dat_q <= '0;
            slv_adr_q <= '0;
            idx_q     <= '0;
            wbs_ack_q <= 1'b0;
            wbs_dat_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            slv_stb_q <= slv_stb_d;
            slv_cyc_q <= slv_cyc_d;
            slv_we_q  <= slv_we_d;
            slv_sel_q <= slv_sel_d;
            slv_dat_q <= slv_dat_d;
            slv_adr_q <= slv_adr_d;
            idx_q     <= idx_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_dat_q <= wbs_dat_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wbs_ack_o   = wbs_ack_q;
    assign wbs_dat_o   = wbs_dat_q;
    assign slv_stb_o   = slv_stb_q;
    assign slv_cyc_o   = slv_cyc_q;
    assign slv_we_o    = slv_we_q;
    assign slv_sel_o   = slv_sel_q;
    assign slv_dat_o   = slv_dat_q;
    assign slv_adr_o   = slv_adr_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

endmodule
